// File: rtl/shift_register_universal.sv
// Universal WIDTH-bit shift register: hold/load/shift/rotate/asr/clear per cycle,
// plus an unattended burst of `count` shifts reported through busy/done.
module shift_register_universal #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0,
    localparam int              CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [2:0] M_HOLD  = 3'd0;
    localparam logic [2:0] M_LOAD  = 3'd1;
    localparam logic [2:0] M_SHL   = 3'd2;
    localparam logic [2:0] M_SHR   = 3'd3;
    localparam logic [2:0] M_ROTL  = 3'd4;
    localparam logic [2:0] M_ROTR  = 3'd5;
    localparam logic [2:0] M_ASR   = 3'd6;
    localparam logic [2:0] M_CLEAR = 3'd7;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, op_q;
    logic [2:0]       mode_reg;
    logic [CW-1:0]    remaining_reg;
    logic             done_reg;
    logic [2:0]       eff_mode;
    logic             accept;
    logic             last_shift;

    // While bursting, the latched mode drives both the datapath and sout.
    assign eff_mode   = (state_reg == BURST) ? mode_reg : mode;
    assign accept     = (state_reg == IDLE) && start && (mode >= M_SHL) && (mode <= M_ASR)
                        && (count != '0);
    assign last_shift = (state_reg == BURST) && (remaining_reg == CW'(1));

    always_comb begin
        op_q = q_reg;
        case (eff_mode)
            M_HOLD:  op_q = q_reg;
            M_LOAD:  op_q = d;
            M_SHL:   op_q = {q_reg[WIDTH-2:0], sin};
            M_SHR:   op_q = {sin, q_reg[WIDTH-1:1]};
            M_ROTL:  op_q = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
            M_ROTR:  op_q = {q_reg[0], q_reg[WIDTH-1:1]};
            M_ASR:   op_q = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
            M_CLEAR: op_q = '0;
            default: op_q = q_reg;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = BURST;
            BURST:   if (last_shift) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = 1'b0;
        case (state_reg)
            BURST:   busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Datapath; the accepting edge only latches the burst, q is left untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg         <= INIT;
            mode_reg      <= M_HOLD;
            remaining_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= last_shift;
            if (accept) begin
                mode_reg      <= mode;
                remaining_reg <= count;
            end else begin
                q_reg <= op_q;
                if (state_reg == BURST) begin
                    remaining_reg <= remaining_reg - CW'(1);
                end
            end
        end
    end

    assign q    = q_reg;
    assign done = done_reg;
    assign sout = ((eff_mode == M_SHL) || (eff_mode == M_ROTL)) ? q_reg[WIDTH-1] : q_reg[0];

endmodule
